imem_loader: RTL

- Writer side of the instruction memory that the fetch/decode path reads.
- Accepts a byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and writes them to consecutive instruction-memory word addresses.
- Holds the CPU core in hold until a complete program has been loaded.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_word_packer.sv | 31 +++
 rtl/imem_loader.sv | 115 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types, loader state encoding and the opcode set also used by the main decoder.
package imem_loader_pkg;

   typedef logic        u1;
   typedef logic [1:0]  u2;
   typedef logic [5:0]  u6;
   typedef logic [7:0]  u8;
   typedef logic [31:0] u32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_WRITE = 3'd2;
   localparam state_t ST_DONE  = 3'd3;
   localparam state_t ST_ERR   = 3'd4;

   localparam u6 OP_RTYPE = 6'h00;
   localparam u6 OP_J     = 6'h02;
   localparam u6 OP_BEQ   = 6'h04;
   localparam u6 OP_ADDI  = 6'h08;
   localparam u6 OP_LW    = 6'h23;
   localparam u6 OP_SW    = 6'h2b;

   function automatic u1 opcode_ok(input u6 op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 6
);
   import imem_loader_pkg::*;

   // A byte moves on a rising edge where byte_valid && byte_ready; the source
   // holds byte_data stable while byte_valid is high and not yet accepted.
   u1                 byte_valid;
   u8                 byte_data;
   u1                 byte_ready;

   u1                 mem_we;
   logic [ADDR_W-1:0] mem_addr;
   u32                mem_wdata;

   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

endinterface

// File: rtl/imem_word_packer.sv
// Shifts accepted bytes into a big-endian 32-bit word and flags the fourth byte.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic byte_strobe,
   input  u8    byte_data,
   output u32   word,
   output u2    byte_cnt,
   output u1    word_ready
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (byte_strobe) begin
         // Earlier bytes move toward the MSBs, so byte 0 ends in [31:24].
         word     <= {word[23:0], byte_data};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_ready = byte_strobe && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, word writes out, core held until done.
// Optional OPCODE_CHECK_EN rejects words whose opcode is outside the supported set.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   imem_loader_if.slave      bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output state_t            dbg_state,
   output u2                 dbg_byte_cnt
);

   localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W-1:0] word_cnt;
   u32                word;
   u1                 word_ready;
   u1                 byte_strobe;
   u1                 accept_start;
   u1                 len_over;
   u1                 last_word;
   u1                 word_ok;

   assign accept_start = (state == ST_IDLE) && start;
   assign len_over     = (len > CAPACITY);
   assign last_word    = ({1'b0, word_cnt} == (len_q - ONE));
   assign byte_strobe  = bus.byte_valid && bus.byte_ready;

`ifdef OPCODE_CHECK_EN
   assign word_ok = opcode_ok(word[31:26]);
`else
   assign word_ok = 1'b1;
`endif

   imem_word_packer u_packer (
      .clk         (clk),
      .resetn      (resetn),
      .clear       (accept_start),
      .byte_strobe (byte_strobe),
      .byte_data   (bus.byte_data),
      .word        (word),
      .byte_cnt    (dbg_byte_cnt),
      .word_ready  (word_ready)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (len == '0)    state_nx = ST_DONE;
               else if (len_over) state_nx = ST_ERR;
               else              state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (word_ready) state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            if (!word_ok)       state_nx = ST_ERR;
            else if (last_word) state_nx = ST_DONE;
            else                state_nx = ST_LOAD;
         end
         ST_DONE: state_nx = ST_IDLE;
         ST_ERR:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         len_q    <= '0;
         word_cnt <= '0;
         cpu_hold <= 1'b1;
         err      <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept_start) begin
            len_q    <= len;
            word_cnt <= '0;
            cpu_hold <= 1'b1;
            err      <= len_over;
         end
         if (state == ST_WRITE) begin
            if (!word_ok)        err      <= 1'b1;
            else if (!last_word) word_cnt <= word_cnt + 1'b1;
         end
         // The core is released only after the done cycle has been seen.
         if (state == ST_DONE) cpu_hold <= 1'b0;
      end
   end

   assign bus.byte_ready = (state == ST_LOAD);
   assign bus.mem_we     = (state == ST_WRITE) && word_ok;
   assign bus.mem_addr   = word_cnt;
   assign bus.mem_wdata  = (state == ST_WRITE) ? word : '0;

   assign busy      = (state == ST_LOAD) || (state == ST_WRITE);
   assign done      = (state == ST_DONE);
   assign dbg_state = state;

endmodule
